fsm_dispatcher: RTL and testbench
=================================

Name: fsm_dispatcher

Overview:
Instruction sequencer for the bus-based datapath. It fetches instruction words from a synchronous instruction ROM, decodes each one, and starts exactly one per-instruction FSM (ALU, move, I/O) through a one-hot start vector. It holds opcode and parameters stable while that FSM runs, waits for its done, then advances the PC. It also provides halt, illegal-opcode and watchdog-timeout handling. It sits above the ALU, move and I/O FSMs, which share the register bus.

Parameters:
PC_W, 8, instruction address width; PC wraps modulo 2^PC_W
TIMEOUT, 64, maximum cycles spent in WAIT_DONE before a timeout error (must be >= 2)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
run  in  1  level; 1 = execute; sampled in IDLE and ADVANCE
clear_err  in  1  pulse; leaves ERROR, returns to IDLE
instr_addr  out  PC_W  ROM address (equals pc)
instr_data  in  16  ROM data, valid 1 cycle after instr_addr changes
fsm_start  out  4  one-hot start: [0] ALU, [1] move, [2] I/O, [3] reserved (never asserted)
fsm_done  in  4  done pulses from the same FSMs
opcode  out  4  IR[15:12]
param1  out  6  IR[11:6]
param2  out  6  IR[5:0]
busy  out  1  1 in any state except IDLE, HALTED, ERROR
halted  out  1  1 in HALTED
error  out  1  1 in ERROR
err_code  out  2  0 none, 1 illegal opcode, 2 timeout
retired  out  16  count of completed instructions; wraps at 2^16

Behaviour:
- Reset (any state, mid-instruction included): state=IDLE; pc, IR, fsm_start, busy, halted, error, err_code, retired all 0; the watchdog counter is cleared on the same edge.
- Decode: 0000-0111 go to ALU (target 0); 1000 MOV goes to move (target 1); 1001 IN and 1010 OUT go to I/O (target 2); 1111 is HALT; 1011-1110 are illegal.
- States and transitions:
  - IDLE: if run=1, go to FETCH; otherwise stay.
  - FETCH: instr_addr=pc; go to LATCH.
  - LATCH: IR <= instr_data; go to DECODE.
  - DECODE: HALT goes to HALTED. Illegal goes to ERROR with err_code=1. Otherwise latch target and go to START.
  - START: fsm_start[target]=1 for exactly this one cycle; clear watchdog; go to WAIT_DONE.
  - WAIT_DONE: only fsm_done[target] is sampled; done bits from other FSMs are ignored. If done=1, go to ADVANCE. Otherwise increment watchdog. If watchdog reaches TIMEOUT-1 with no done, go to ERROR with err_code=2. If done arrives on that same cycle, done wins.
  - ADVANCE: pc <= pc+1 (wraps from 2^PC_W-1 to 0); retired <= retired+1. If run=1, go to FETCH; otherwise go to IDLE (paused; pc is kept).
  - HALTED: stays here until reset; run is ignored; pc still points at the HALT word.
  - ERROR: pc and IR are frozen. clear_err=1 goes to IDLE and clears err_code. Reset takes priority over clear_err.
- opcode/param1/param2 come straight from IR: stable from DECODE through ADVANCE and unchanged while IDLE.
- fsm_start is registered and never has more than one bit set. fsm_done sampled in START is ignored.
- Minimum cost per instruction: 6 cycles (FETCH, LATCH, DECODE, START, WAIT_DONE, ADVANCE) plus the target FSM's latency.
- Dropping run mid-instruction does not abort; the instruction completes and the dispatcher pauses in ADVANCE.

Decomposition:
- Shared package dispatch_pkg holds: state encoding; opcode constants (OP_MOV=4'b1000, OP_IN=4'b1001, OP_OUT=4'b1010, OP_HALT=4'b1111); target indices (TGT_ALU=0, TGT_MOV=1, TGT_IO=2); err_code constants.
- One natural sub-module: dispatch_decode (combinational: opcode -> target, is_halt, is_illegal), reused by the bench's reference model.

Test Plan:
- ROM[0]=16'h0_0C2 (ALU op 0, p1=3, p2=2) with run=1; the ALU model returns done 5 cycles after start. Required: fsm_start=4'b0001 for exactly one cycle; opcode=0, param1=3, param2=2 held until ADVANCE; pc goes 0->1; retired=1.
- ROM = {MOV, IN, OUT, HALT}. Required: starts occur in the order 0010, 0100, 0100; HALTED is reached with pc=3 and retired=3; halted=1 and busy=0.
- ROM[0]=16'hB000. Required: ERROR entered from DECODE with err_code=1 and no fsm_start pulse. A clear_err pulse returns to IDLE with err_code=0.
- TIMEOUT=8 and the ALU never returns done. Required: ERROR with err_code=2 exactly 8 cycles after the START cycle. In a second run, done arrives on the 8th WAIT_DONE cycle; required: ADVANCE, no error.
- PC_W=2, four ALU ops, run held at 1. Required: pc wraps 3->0 and fetch continues; retired=5 after the 5th done.
- Assert reset while in WAIT_DONE. Required: on the next edge state=IDLE, pc=0, retired=0, fsm_start=0. A late fsm_done arriving after reset is ignored.

Source files
------------

// File: rtl/dispatch_pkg.sv
// dispatch_pkg: shared definitions for the instruction dispatcher.
//   - state_t   : dispatcher FSM state encoding (also exported for debug)
//   - OP_*      : opcode constants that do not belong to the ALU range
//   - TGT_*     : indices into the fsm_start / fsm_done vectors
//   - ERR_*     : err_code values
//   - tgt_onehot: target index -> one-hot start vector
package dispatch_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_LATCH     = 4'd2,
    S_DECODE    = 4'd3,
    S_START     = 4'd4,
    S_WAIT_DONE = 4'd5,
    S_ADVANCE   = 4'd6,
    S_HALTED    = 4'd7,
    S_ERROR     = 4'd8
  } state_t;

  localparam logic [3:0] OP_MOV  = 4'b1000;
  localparam logic [3:0] OP_IN   = 4'b1001;
  localparam logic [3:0] OP_OUT  = 4'b1010;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [1:0] TGT_ALU = 2'd0;
  localparam logic [1:0] TGT_MOV = 2'd1;
  localparam logic [1:0] TGT_IO  = 2'd2;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  function automatic logic [3:0] tgt_onehot(input logic [1:0] tgt);
    logic [3:0] v;
    v = 4'b0000;
    v[tgt] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/dispatch_decode.sv
// dispatch_decode: purely combinational opcode classifier.
// Ports:
//   opcode     in  4  instruction opcode (IR[15:12])
//   target     out 2  FSM index to start (meaningful only when legal and not HALT)
//   is_halt    out 1  opcode is HALT
//   is_illegal out 1  opcode is in the unused range 1011..1110
module dispatch_decode
  import dispatch_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [1:0] target,
  output logic       is_halt,
  output logic       is_illegal
);

  always_comb begin
    target     = TGT_ALU;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    // The whole lower half of the opcode space is ALU operations.
    if (opcode[3]) begin
      case (opcode)
        OP_MOV:         target = TGT_MOV;
        OP_IN, OP_OUT:  target = TGT_IO;
        OP_HALT:        is_halt = 1'b1;
        default:        is_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/fsm_dispatcher.sv
// fsm_dispatcher: fetches 16-bit instruction words from a synchronous ROM,
// decodes them and starts one per-instruction FSM (ALU / move / I/O) at a time.
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   run                 level, 1 = execute (sampled in IDLE and ADVANCE)
//   clear_err           pulse, leaves ERROR back to IDLE
//   instr_addr/data     ROM address (= pc) and data (1-cycle read latency)
//   fsm_start/fsm_done  one-hot start pulse out, done pulses in
//   opcode/param1/param2  fields of the instruction register
//   busy/halted/error/err_code  status
//   retired             completed-instruction count (wraps)
//   state_dbg           current FSM state, for observation only
//
// Start/done handshake: fsm_start[t] is a registered single-cycle pulse issued
// in START; opcode/param1/param2 are stable from DECODE until the dispatcher
// leaves ADVANCE. The target FSM answers with a single-cycle fsm_done[t] pulse
// at any time after START; only the bit of the running target is honoured and
// only while in WAIT_DONE, so stray or late done pulses are harmless.
module fsm_dispatcher
  import dispatch_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int TIMEOUT = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            run,
  input  logic            clear_err,
  output logic [PC_W-1:0] instr_addr,
  input  logic [15:0]     instr_data,
  output logic [3:0]      fsm_start,
  input  logic [3:0]      fsm_done,
  output logic [3:0]      opcode,
  output logic [5:0]      param1,
  output logic [5:0]      param2,
  output logic            busy,
  output logic            halted,
  output logic            error,
  output logic [1:0]      err_code,
  output logic [15:0]     retired,
  output logic [3:0]      state_dbg
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [1:0]        target_q, target_d;
  logic [3:0]        start_q, start_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [1:0]        err_q, err_d;
  logic [15:0]       ret_q, ret_d;

  logic [1:0]        dec_target;
  logic              dec_halt;
  logic              dec_illegal;

  dispatch_decode u_decode (
    .opcode     (ir_q[15:12]),
    .target     (dec_target),
    .is_halt    (dec_halt),
    .is_illegal (dec_illegal)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    target_d = target_q;
    start_d  = 4'b0000;
    wd_d     = wd_q;
    err_d    = err_q;
    ret_d    = ret_q;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      // pc already drives instr_addr; the ROM word appears during LATCH.
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        ir_d    = instr_data;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (dec_halt) begin
          state_d = S_HALTED;
        end else if (dec_illegal) begin
          err_d   = ERR_ILLEGAL;
          state_d = S_ERROR;
        end else begin
          target_d = dec_target;
          // Loaded here so the registered pulse lines up with START.
          start_d  = tgt_onehot(dec_target);
          state_d  = S_START;
        end
      end
      S_START: begin
        wd_d    = '0;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // done is checked before the watchdog so a done on the last
        // allowed cycle still retires the instruction.
        if (fsm_done[target_q]) begin
          state_d = S_ADVANCE;
        end else if (wd_q == WD_LAST) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_ERROR;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_ADVANCE: begin
        pc_d    = pc_q + PC_W'(1);
        ret_d   = ret_q + 16'd1;
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_HALTED: state_d = S_HALTED;
      S_ERROR: begin
        if (clear_err) begin
          err_d   = ERR_NONE;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      target_q <= TGT_ALU;
      start_q  <= 4'b0000;
      wd_q     <= '0;
      err_q    <= ERR_NONE;
      ret_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      target_q <= target_d;
      start_q  <= start_d;
      wd_q     <= wd_d;
      err_q    <= err_d;
      ret_q    <= ret_d;
    end
  end

  assign instr_addr = pc_q;
  assign fsm_start  = start_q;
  assign opcode     = ir_q[15:12];
  assign param1     = ir_q[11:6];
  assign param2     = ir_q[5:0];
  assign busy       = (state_q != S_IDLE) && (state_q != S_HALTED) && (state_q != S_ERROR);
  assign halted     = (state_q == S_HALTED);
  assign error      = (state_q == S_ERROR);
  assign err_code   = err_q;
  assign retired    = ret_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_fsm_dispatcher.sv
module tb_fsm_dispatcher;
  import dispatch_pkg::*;

  localparam int PC_W    = 2;
  localparam int TIMEOUT = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic            run = 1'b0;
  logic            clear_err = 1'b0;
  logic [PC_W-1:0] instr_addr;
  logic [15:0]     instr_data;
  logic [3:0]      fsm_start;
  logic [3:0]      fsm_done;
  logic [3:0]      opcode;
  logic [5:0]      param1;
  logic [5:0]      param2;
  logic            busy;
  logic            halted;
  logic            error;
  logic [1:0]      err_code;
  logic [15:0]     retired;
  logic [3:0]      state_dbg;

  fsm_dispatcher #(.PC_W(PC_W), .TIMEOUT(TIMEOUT)) dut (
    .clock      (clk),
    .reset      (reset),
    .run        (run),
    .clear_err  (clear_err),
    .instr_addr (instr_addr),
    .instr_data (instr_data),
    .fsm_start  (fsm_start),
    .fsm_done   (fsm_done),
    .opcode     (opcode),
    .param1     (param1),
    .param2     (param2),
    .busy       (busy),
    .halted     (halted),
    .error      (error),
    .err_code   (err_code),
    .retired    (retired),
    .state_dbg  (state_dbg)
  );

  // ---------------- environment models ----------------
  logic [15:0] rom [4];
  always @(posedge clk) instr_data <= rom[instr_addr];

  // Target FSM responder: done pulse lat[t] cycles after the start cycle
  // (lat 0 = never answers). done_extra injects stray done bits.
  int         lat [3];
  int         cnt [3];
  logic [3:0] done_resp = 4'b0;
  logic [3:0] done_extra = 4'b0;
  logic       mon_en = 1'b0;
  assign fsm_done = done_resp | done_extra;

  always @(negedge clk) begin
    done_resp = 4'b0;
    for (int t = 0; t < 3; t++) begin
      if (cnt[t] > 0) begin
        cnt[t]--;
        if (cnt[t] == 0) done_resp[t] = 1'b1;
      end
      if (mon_en && fsm_start[t] === 1'b1) cnt[t] = lat[t];
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [19:0] exp_q[$];   // {fsm_start, IR} expected for each start pulse

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [19:0] e;
    if (mon_en && fsm_start !== 4'b0) begin
      if (exp_q.size() == 0) begin
        check_val("start_unexpected", 32'(fsm_start), 32'h0);
      end else begin
        e = exp_q.pop_front();
        check_val("start_vec", 32'(fsm_start), 32'(e[19:16]));
        check_val("start_ir", 32'({opcode, param1, param2}), 32'(e[15:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_start(input logic [3:0] vec, input logic [15:0] ir);
    exp_q.push_back({vec, ir});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run = 1'b0;
    clear_err = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_state(input string tag, input state_t s, input int max_cyc);
    int n;
    n = 0;
    while (state_dbg !== s && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, 32'(state_dbg), 32'(s));
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
  endtask

  // Counts consecutive WAIT_DONE cycles, starting at the negedge of START.
  task automatic count_wait(output int n);
    n = 0;
    @(negedge clk);
    while (state_dbg === S_WAIT_DONE && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    int n;
    for (int i = 0; i < 4; i++) rom[i] = 16'hF000;
    for (int t = 0; t < 3; t++) begin
      lat[t] = 3;
      cnt[t] = 0;
    end
    @(negedge clk);
    do_reset();
    mon_en = 1'b1;

    // Reset state
    check_val("rst_state", 32'(state_dbg), 32'(S_IDLE));
    check_val("rst_pc", 32'(instr_addr), 32'h0);
    check_val("rst_retired", 32'(retired), 32'h0);
    check_val("rst_start", 32'(fsm_start), 32'h0);
    check_val("rst_status", 32'({busy, halted, error, err_code}), 32'h0);
    check_val("rst_ir", 32'({opcode, param1, param2}), 32'h0);

    // 1: single ALU op, 5-cycle latency, stray done bits ignored
    rom[0] = 16'h00C2;
    rom[1] = 16'hF000;
    lat[0] = 5;
    push_start(4'b0001, 16'h00C2);
    run = 1'b1;
    wait_state("t1_wait", S_WAIT_DONE, 20);
    done_extra = 4'b0110;
    @(negedge clk);
    done_extra = 4'b0000;
    check_val("t1_stray_done", 32'(state_dbg), 32'(S_WAIT_DONE));
    check_val("t1_busy", 32'(busy), 32'h1);
    wait_state("t1_adv", S_ADVANCE, 20);
    check_val("t1_hold_ir", 32'({opcode, param1, param2}), 32'h0C2);
    check_val("t1_pc_before", 32'(instr_addr), 32'h0);
    run = 1'b0;
    @(negedge clk);
    check_val("t1_idle", 32'(state_dbg), 32'(S_IDLE));
    check_val("t1_pc", 32'(instr_addr), 32'h1);
    check_val("t1_retired", 32'(retired), 32'h1);
    check_val("t1_ir_idle", 32'({opcode, param1, param2}), 32'h0C2);
    check_val("t1_sb_empty", 32'(exp_q.size()), 32'h0);

    // 2: MOV, IN, OUT, HALT
    do_reset();
    rom[0] = 16'h8041; rom[1] = 16'h9082; rom[2] = 16'hA0C3; rom[3] = 16'hF000;
    lat[1] = 3;
    lat[2] = 2;
    push_start(4'b0010, 16'h8041);
    push_start(4'b0100, 16'h9082);
    push_start(4'b0100, 16'hA0C3);
    run = 1'b1;
    wait_state("t2_halted", S_HALTED, 200);
    check_val("t2_pc", 32'(instr_addr), 32'h3);
    check_val("t2_retired", 32'(retired), 32'h3);
    check_val("t2_flags", 32'({halted, busy, error}), 32'b100);
    repeat (5) @(negedge clk);
    check_val("t2_stays_halted", 32'(state_dbg), 32'(S_HALTED));
    check_val("t2_sb_empty", 32'(exp_q.size()), 32'h0);

    // 3: illegal opcode, then clear_err
    do_reset();
    rom[0] = 16'hB000;
    run = 1'b1;
    wait_state("t3_error", S_ERROR, 20);
    check_val("t3_err_code", 32'(err_code), 32'(ERR_ILLEGAL));
    check_val("t3_flags", 32'({error, busy, halted}), 32'b100);
    check_val("t3_pc", 32'(instr_addr), 32'h0);
    run = 1'b0;
    repeat (2) @(negedge clk);
    check_val("t3_stays_error", 32'(state_dbg), 32'(S_ERROR));
    pulse_clear();
    check_val("t3_cleared", 32'(state_dbg), 32'(S_IDLE));
    check_val("t3_err_cleared", 32'({error, err_code}), 32'h0);

    // 4a: watchdog timeout, ALU never answers
    do_reset();
    rom[0] = 16'h0123;
    lat[0] = 0;
    push_start(4'b0001, 16'h0123);
    run = 1'b1;
    wait_state("t4a_start", S_START, 20);
    count_wait(n);
    check_val("t4a_wait_cycles", 32'(n), 32'(TIMEOUT));
    check_val("t4a_error", 32'(state_dbg), 32'(S_ERROR));
    check_val("t4a_err_code", 32'(err_code), 32'(ERR_TIMEOUT));
    run = 1'b0;
    pulse_clear();
    check_val("t4a_cleared", 32'({state_dbg, err_code}), 32'({S_IDLE, ERR_NONE}));

    // 4b: done arrives on the last allowed WAIT_DONE cycle
    do_reset();
    lat[0] = TIMEOUT;
    push_start(4'b0001, 16'h0123);
    run = 1'b1;
    wait_state("t4b_start", S_START, 20);
    count_wait(n);
    check_val("t4b_wait_cycles", 32'(n), 32'(TIMEOUT));
    check_val("t4b_advance", 32'(state_dbg), 32'(S_ADVANCE));
    check_val("t4b_no_error", 32'({error, err_code}), 32'h0);
    run = 1'b0;
    @(negedge clk);
    check_val("t4b_retired", 32'(retired), 32'h1);

    // 5: pc wrap with run held high
    do_reset();
    rom[0] = 16'h0041; rom[1] = 16'h1082; rom[2] = 16'h20C3; rom[3] = 16'h3104;
    lat[0] = 2;
    for (int i = 0; i < 6; i++) push_start(4'b0001, rom[i % 4]);
    run = 1'b1;
    n = 0;
    while (retired !== 16'd5 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_val("t5_retired5", 32'(retired), 32'h5);
    check_val("t5_pc_wrapped", 32'(instr_addr), 32'h1);
    check_val("t5_refetch", 32'(state_dbg), 32'(S_FETCH));
    run = 1'b0;
    wait_state("t5_idle", S_IDLE, 50);
    check_val("t5_retired6", 32'(retired), 32'h6);
    check_val("t5_pc_final", 32'(instr_addr), 32'h2);
    check_val("t5_sb_empty", 32'(exp_q.size()), 32'h0);

    // 6: reset while in WAIT_DONE, late done ignored
    rom[2] = 16'h2345;
    lat[0] = 6;
    push_start(4'b0001, 16'h2345);
    run = 1'b1;
    wait_state("t6_wait", S_WAIT_DONE, 20);
    @(negedge clk);
    reset = 1'b1;
    run = 1'b0;
    @(negedge clk);
    check_val("t6_rst_state", 32'(state_dbg), 32'(S_IDLE));
    check_val("t6_rst_pc", 32'(instr_addr), 32'h0);
    check_val("t6_rst_retired", 32'(retired), 32'h0);
    check_val("t6_rst_start", 32'(fsm_start), 32'h0);
    check_val("t6_rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check_val("t6_late_done", 32'({state_dbg, retired}), 32'({S_IDLE, 16'h0}));
    check_val("t6_sb_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
